// File: rtl/uart_bus_responder.sv
// Memory-mapped 8N1 UART (TXD / RXD / CON word registers) on the CPU data bus, with a level interrupt output.
// Latency: reads are zero-wait combinational; TX line starts the cycle after a TXD write; irq trails the flags by 1 clk.
// Backpressure: none on the bus; a TXD write while tx_busy is dropped, a new RX byte overwrites an unread one (overrun).
// Optional even parity on both directions: define UART_PARITY_EN.
module uart_bus_responder #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        UART_RX,
  output logic        UART_TX,
  output logic        irq
);
  localparam int unsigned   DIV      = CLK_FREQ / BAUD;
  localparam int unsigned   CW       = $clog2(DIV);
  localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF     = CW'(DIV / 2 - 1);
  localparam logic [31:0]   RXD_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0]   CON_ADDR = BASE_ADDR + 32'd8;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} line_state_t;

  // Word decode; the byte-lane bits of the address take no part.
  logic hit_txd, hit_rxd, hit_con;
  logic rd_rxd, rd_con, wr_txd, wr_con;
  assign hit_txd = (addr[31:2] == BASE_ADDR[31:2]);
  assign hit_rxd = (addr[31:2] == RXD_ADDR[31:2]);
  assign hit_con = (addr[31:2] == CON_ADDR[31:2]);
  assign rd_rxd  = rd & hit_rxd;
  assign rd_con  = rd & hit_con;
  assign wr_txd  = wr & hit_txd;
  assign wr_con  = wr & hit_con;

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  logic       tx_ie, rx_ie, tx_done, tx_busy, rx_valid, frame_err, overrun, parity_err;
  logic [7:0] rxd;
  logic [7:0] con;
  assign con = {parity_err, overrun, frame_err, tx_busy, rx_valid, tx_done, rx_ie, tx_ie};

  // Combinational read mux; idle bus reads as zero.
  always_comb begin
    rdata = '0;
    if (rd_rxd)      rdata = {24'd0, rxd};
    else if (rd_con) rdata = {24'd0, con};
  end

  // Software-writable interrupt enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ie <= 1'b0;
      rx_ie <= 1'b0;
    end else if (wr_con) begin
      tx_ie <= wdata[0];
      rx_ie <= wdata[1];
    end
  end

  // ---------------- transmitter ----------------
  line_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
`ifdef UART_PARITY_EN
  logic          tx_par;
`endif

  // TX FSM: each line state lasts DIV clocks; the line output is registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
      UART_TX  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      if (rd_con) tx_done <= 1'b0;
      if (tx_state == S_IDLE) begin
        if (wr_txd) begin
          tx_shift <= wdata[7:0];
`ifdef UART_PARITY_EN
          tx_par   <= ^wdata[7:0];
`endif
          tx_cnt   <= '0;
          tx_busy  <= 1'b1;
          UART_TX  <= 1'b0;
          tx_state <= S_START;
        end
      end else if (tx_cnt != LAST) begin
        tx_cnt <= tx_cnt + 1'b1;
      end else begin
        tx_cnt <= '0;
        case (tx_state)
          S_START: begin
            UART_TX  <= tx_shift[0];
            tx_bit   <= '0;
            tx_state <= S_DATA;
          end
          S_DATA: begin
            if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              UART_TX  <= tx_par;
              tx_state <= S_PAR;
`else
              UART_TX  <= 1'b1;
              tx_state <= S_STOP;
`endif
            end else begin
              UART_TX  <= tx_shift[1];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 1'b1;
            end
          end
          S_PAR: begin
            UART_TX  <= 1'b1;
            tx_state <= S_STOP;
          end
          S_STOP: begin
            // Done wins over a CON read clearing it in the same cycle.
            UART_TX  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
            tx_state <= S_IDLE;
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- receiver ----------------
  logic rx_sync1, rx_sync2, rx_prev;

  // Two-flop synchronizer plus one history bit for falling-edge detection; idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= UART_RX;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  line_state_t   rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
`ifdef UART_PARITY_EN
  logic          rx_par_bad;
`endif

  // RX FSM: half a bit to the start mid-point, then whole bits; commits or flags at the stop mid-point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
`ifdef UART_PARITY_EN
      rx_par_bad <= 1'b0;
`endif
      rxd        <= '0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (rd_rxd) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      if (rd_con) begin
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_sync2) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
`ifdef UART_PARITY_EN
            if (rx_bit == 3'd7) rx_state <= S_PAR;
`else
            if (rx_bit == 3'd7) rx_state <= S_STOP;
`endif
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        S_PAR: begin
          if (rx_cnt == LAST) begin
            rx_cnt     <= '0;
            rx_par_bad <= (^rx_shift) ^ rx_sync2;
            if ((^rx_shift) ^ rx_sync2) parity_err <= 1'b1;
            rx_state   <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (rx_cnt == LAST) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
            if (!rx_sync2) begin
              frame_err <= 1'b1;
`ifdef UART_PARITY_EN
            end else if (!rx_par_bad) begin
`else
            end else begin
`endif
              // A same-cycle RXD read consumes the old byte, so no overrun then.
              rxd      <= rx_shift;
              rx_valid <= 1'b1;
              overrun  <= rx_valid & ~rd_rxd;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // Registered level interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= (tx_ie & tx_done) | (rx_ie & rx_valid);
  end
endmodule

// File: tb/tb_uart_bus_responder.sv
// Bench for uart_bus_responder at DIV=16: bus reads and TX line frames are checked by
// monitors popping expected values from queues filled by the stimulus thread.
module tb_uart_bus_responder;
  localparam int unsigned DIV = 16;
`ifdef UART_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam logic [31:0] TXD_A = 32'h4000_0018;
  localparam logic [31:0] RXD_A = 32'h4000_001C;
  localparam logic [31:0] CON_A = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        UART_RX = 1'b1;
  logic        UART_TX;
  logic        irq;

  uart_bus_responder #(.CLK_FREQ(16), .BAUD(1), .BASE_ADDR(32'h4000_0018)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .UART_RX(UART_RX), .UART_TX(UART_TX), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [7:0]  tx_exp_q[$];
  logic        tx_mon_en = 1'b1;
  logic [7:0]  tx_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick(1);
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(nm);
    addr = a; rd = 1'b1;
    tick(1);
    rd = 1'b0; addr = '0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    UART_RX = 1'b0; tick(DIV);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i]; tick(DIV);
    end
`ifdef UART_PARITY_EN
    UART_RX = (^b) ^ par_flip; tick(DIV);
`else
    if (par_flip) UART_RX = 1'b1;
`endif
    UART_RX = stop_bit; tick(DIV);
    UART_RX = 1'b1;
  endtask

  // Bus read monitor: one pop per cycle with rd high, compared mid-cycle.
  always @(negedge clk) begin
    if (rd === 1'b1) begin
      if (rd_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected actual=%h expected=none", rdata);
      end else begin
        chk(rd_name_q.pop_front(), rdata, rd_exp_q.pop_front());
      end
    end
  end

  // TX line monitor: decodes each frame at bit mid-points and checks it against the expected bytes.
  initial begin
    forever begin
      @(negedge UART_TX);
      if (tx_mon_en) begin
        repeat (DIV / 2) @(negedge clk);
        chk("tx_start", UART_TX, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          tx_b[i] = UART_TX;
        end
`ifdef UART_PARITY_EN
        repeat (DIV) @(negedge clk);
        chk("tx_parity", UART_TX, ^tx_b);
`endif
        repeat (DIV) @(negedge clk);
        chk("tx_stop", UART_TX, 1);
        if (tx_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected actual=%h expected=none", tx_b);
        end else begin
          chk("tx_byte", tx_b, tx_exp_q.pop_front());
        end
      end
    end
  end

  int n;
  int w;
  int lows;

  initial begin
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    chk("rst_uart_tx", UART_TX, 1);
    chk("rst_irq", irq, 0);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    tick(1);
    addr = CON_A; #1;
    chk("rdata_no_rd", rdata, 0);
    addr = '0;
    tick(1);
    bus_rd(CON_A, 32'h00, "con_reset");
    bus_rd(RXD_A, 32'h00, "rxd_reset");

    // Enables are the only writable CON bits.
    bus_wr(CON_A, 32'hFF);
    bus_rd(CON_A, 32'h03, "con_ie_only");

    // TX 0x55, second write while busy must vanish.
    tx_exp_q.push_back(8'h55);
    bus_wr(TXD_A, 32'h55);
    w = cyc;
    bus_wr(TXD_A, 32'hAA);
    bus_rd(CON_A, 32'h13, "con_tx_busy");
    n = 0;
    while (irq !== 1'b1 && n < 400) begin tick(1); n++; end
    chk("tx_irq_latency", cyc - w, 16 * FRAME_BITS + 1);
    bus_rd(CON_A, 32'h07, "con_tx_done");
    bus_rd(CON_A, 32'h03, "con_tx_done_clr");
    tick(1);
    chk("irq_tx_clr", irq, 0);

    // RX 0xA3.
    send_rx(8'hA3, 1'b1, 1'b0);
    tick(2);
    chk("irq_rx", irq, 1);
    bus_rd(CON_A, 32'h0B, "con_rx_valid");
    bus_rd(RXD_A, 32'hA3, "rxd_a3");
    tick(1);
    chk("irq_rx_clr", irq, 0);
    bus_rd(CON_A, 32'h03, "con_rx_clr");

    // Overrun: two frames, no read.
    send_rx(8'h11, 1'b1, 1'b0);
    send_rx(8'h22, 1'b1, 1'b0);
    tick(4);
    bus_rd(CON_A, 32'h4B, "con_overrun");
    bus_rd(RXD_A, 32'h22, "rxd_22");
    bus_rd(CON_A, 32'h03, "con_overrun_clr");

    // Short glitch on the idle line, then a normal frame.
    UART_RX = 1'b0; tick(4); UART_RX = 1'b1;
    tick(40);
    bus_rd(CON_A, 32'h03, "con_glitch");
    send_rx(8'h5A, 1'b1, 1'b0);
    tick(4);
    bus_rd(RXD_A, 32'h5A, "rxd_5a");

    // Framing error: byte discarded, flag cleared by CON read.
    send_rx(8'h3C, 1'b0, 1'b0);
    tick(4);
    bus_rd(CON_A, 32'h23, "con_frame_err");
    bus_rd(CON_A, 32'h03, "con_frame_err_clr");
    bus_rd(RXD_A, 32'h5A, "rxd_frame_discard");

    // Reset in the middle of a TX frame with RX flags pending.
    send_rx(8'hA5, 1'b1, 1'b0);
    tick(2);
    chk("irq_pre_reset", irq, 1);
    tx_mon_en = 1'b0;
    bus_wr(TXD_A, 32'h00);
    tick(40);
    chk("tx_mid_frame_low", UART_TX, 0);
    reset = 1'b0;
    #1;
    chk("rst_mid_uart_tx", UART_TX, 1);
    chk("rst_mid_irq", irq, 0);
    tick(3);
    reset = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (UART_TX !== 1'b1) lows++;
    end
    chk("tx_no_resume", lows, 0);
    bus_rd(CON_A, 32'h00, "con_after_reset");
    bus_rd(RXD_A, 32'h00, "rxd_after_reset");

`ifdef UART_PARITY_EN
    tx_mon_en = 1'b1;
    tx_exp_q.push_back(8'h07);
    bus_wr(TXD_A, 32'h07);
    tick(16 * FRAME_BITS + 8);
    send_rx(8'h07, 1'b1, 1'b1);
    tick(4);
    bus_rd(CON_A, 32'h80, "con_parity_err");
    bus_rd(CON_A, 32'h00, "con_parity_err_clr");
`endif

    tick(20);
    chk("rd_queue_drained", rd_exp_q.size(), 0);
    chk("tx_queue_drained", tx_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
